add_round_key_pipe: RTL
=======================

Name: add_round_key_pipe

Overview:
- Parametrised, pipelined AddRoundKey engine for the RISC-V crypto datapath; successor to the single-register key-addition stage.
- Holds an on-chip round-key file of NUM_KEYS entries, written by the key-expansion unit.
- Each accepted state is XORed with the key selected by its round index and passed through a valid/ready elastic pipeline of PIPE_STAGES registers.
- Flags bad key selects and supports one-cycle key zeroisation.

Parameters:
- DATA_W, 128, state/key width in bits; any multiple of 32.
- NUM_KEYS, 15, round-key file depth; covers AES-128/192/256.
- PIPE_STAGES, 1, pipeline registers from input to output; legal range 1..4.
- KIDX_W, $clog2(NUM_KEYS), derived index width; not overridden.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- key_we_i  in  1  key-file write strobe.
- key_waddr_i  in  KIDX_W  key-file write index.
- key_wdata_i  in  DATA_W  round key to write.
- key_clr_i  in  1  zeroise all keys and clear all loaded flags.
- valid_i  in  1  input state valid.
- ready_o  out  1  block accepts input this cycle.
- state_i  in  DATA_W  input state.
- round_i  in  KIDX_W  index of the round key to apply.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream accepts output.
- state_o  out  DATA_W  state_i XOR key[round_i].
- err_o  out  1  qualified by valid_o; selected key was out of range or not loaded.

Behaviour:
- Reset is sampled at the clock edge while rst_n=0. Reset clears:
  - all stage valid bits, data and err bits;
  - all key entries and all loaded flags.
- During reset and after it: valid_o=0, state_o=0, err_o=0. ready_o=0 while rst_n=0 and 1 on the first cycle after release.
- Key file:
  - A write with key_we_i=1 and key_waddr_i<NUM_KEYS stores key_wdata_i and sets the entry's loaded flag at the edge.
  - A write with key_waddr_i>=NUM_KEYS is ignored.
  - A read of an entry in the same cycle it is written returns the old value; the new key applies from the next cycle.
- Key clear: key_clr_i=1 zeroes every entry and loaded flag at the edge and wins over a simultaneous write. In-flight pipeline data is unaffected.
- Input accept happens when valid_i && ready_o. At accept, stage 1 captures:
  - data = state_i ^ key[round_i];
  - err = (round_i>=NUM_KEYS) || !loaded[round_i].
- On err, the captured data is forced to all-zero; key material must never leak through a bad select.
- Pipeline:
  - Stages 2..PIPE_STAGES are delay registers carrying {valid, data, err}.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances when ready_i=1.
  - ready_o = !valid[1] || advance[1], combinational from ready_i through the stage chain. No skid buffer.
- Latency and throughput:
  - An accept at edge n presents valid_o=1 from edge n+PIPE_STAGES-1 onward, i.e. PIPE_STAGES register stages.
  - Throughput is one state per cycle when ready_i is held high.
- Backpressure: while valid_o=1 and ready_i=0, state_o and err_o are held stable. Upstream stages fill; ready_o falls once every stage is full.
- Output gating: whenever a stage is invalid or drained, its data and err registers are cleared to 0. state_o=0 and err_o=0 whenever valid_o=0.
- Reset mid-operation: all in-flight items are discarded, the key file is cleared, and no output handshake occurs on the reset cycle.
- Ordering: outputs leave in acceptance order. No reordering or drops.

Test Plan:
- FIPS-197 vector, PIPE_STAGES=1:
  - Stimulus: write key[0]=2b7e151628aed2a6abf7158809cf4f3c, then send state_i=3243f6a8885a308d313198a2e0370734, round_i=0, ready_i=1.
  - Required: one cycle later, valid_o=1, state_o=193de3bea0f4e22b9ac68d2ae9f84808, err_o=0.
- Bad select:
  - Stimulus: send with round_i=3 while entry 3 is unloaded; then with round_i=15 at NUM_KEYS=15.
  - Required: each result has valid_o=1, err_o=1, state_o=0.
- Streaming with backpressure, PIPE_STAGES=3:
  - Stimulus: 10 back-to-back states with ready_i toggled pseudo-randomly.
  - Required: all 10 results in order and equal to the scoreboard. Outputs are stable while stalled, and ready_o=0 only when all 3 stages are full and ready_i=0.
- Write/read collision and clear:
  - Stimulus: write key[2]=K2, and in the same cycle accept a state with round_i=2. Then assert key_clr_i together with key_we_i to entry 2.
  - Required: the first result uses the old key[2] (zero, err_o=1 if previously unloaded). Afterwards key[2] remains unloaded.
- Mid-flight reset:
  - Stimulus: fill PIPE_STAGES=4 with four states, then assert rst_n=0 for one cycle.
  - Required: valid_o=0 and state_o=0 from the next edge, no stale results appear after release, and a fresh send errs until keys are reloaded.

Source files
------------

// File: rtl/add_round_key_pipe.sv
// add_round_key_pipe: round-key file plus elastic valid/ready pipeline applying state ^ key[round].
module add_round_key_pipe #(
  parameter int DATA_W      = 128,
  parameter int NUM_KEYS    = 15,
  parameter int PIPE_STAGES = 1,
  parameter int KIDX_W      = $clog2(NUM_KEYS)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              key_we_i,
  input  logic [KIDX_W-1:0] key_waddr_i,
  input  logic [DATA_W-1:0] key_wdata_i,
  input  logic              key_clr_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] state_i,
  input  logic [KIDX_W-1:0] round_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] state_o,
  output logic              err_o
);
  localparam logic [KIDX_W:0] NK = NUM_KEYS[KIDX_W:0];
  logic [DATA_W-1:0]      key_q [NUM_KEYS];
  logic [DATA_W-1:0]      key_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]    loaded_q, loaded_d;
  logic [PIPE_STAGES-1:0] valid_q, valid_d, err_q, err_d, adv;
  logic [DATA_W-1:0]      data_q [PIPE_STAGES];
  logic [DATA_W-1:0]      data_d [PIPE_STAGES];
  logic                   ok, accept, sel_bad;
  logic [DATA_W-1:0]      in_data;
  always_comb begin
    key_d    = key_q;
    loaded_d = loaded_q;
    if (key_clr_i) begin
      key_d    = '{default: '0};
      loaded_d = '0;
    end else if (key_we_i && ({1'b0, key_waddr_i} < NK)) begin
      key_d[key_waddr_i]    = key_wdata_i;
      loaded_d[key_waddr_i] = 1'b1;
    end
  end
  // Bad selects never expose key material: the captured data is zeroed.
  always_comb begin
    sel_bad = ({1'b0, round_i} >= NK) ? 1'b1 : !loaded_q[round_i];
    in_data = sel_bad ? '0 : state_i ^ key_q[round_i];
  end
  // ok walks from the output back to stage 1: "this stage can take a new item".
  always_comb begin
    adv = '0;
    ok  = ready_i;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] && ok;
      ok     = ok || !valid_q[k];
    end
  end
  assign ready_o = rst_n && ok;
  assign accept  = valid_i && ready_o;
  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    if (accept) begin
      valid_d[0] = 1'b1;
      err_d[0]   = sel_bad;
      data_d[0]  = in_data;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
      err_d[0]   = 1'b0;
      data_d[0]  = '0;
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (adv[k-1]) begin
        valid_d[k] = 1'b1;
        err_d[k]   = err_q[k-1];
        data_d[k]  = data_q[k-1];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
        err_d[k]   = 1'b0;
        data_d[k]  = '0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      key_q    <= '{default: '0};
      loaded_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      data_q   <= '{default: '0};
    end else begin
      key_q    <= key_d;
      loaded_q <= loaded_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end
  assign valid_o = valid_q[PIPE_STAGES-1];
  assign state_o = data_q[PIPE_STAGES-1];
  assign err_o   = err_q[PIPE_STAGES-1];
endmodule
